mic_i2s_rx: RTL

- I2S-style PCM receiver for the microphone/ADC path: the capture-side counterpart of the speaker serializer.
- Runs as bus master: derives bclk and rlclk from clk, samples the serial datain line, and deserializes MSB-first left/right words.
- Presents each completed stereo frame as a parallel word pair with a valid strobe to the downstream audio buffer/FSM.
- Single clock domain: bclk is a generated output, and all logic uses clk with internal rise/fall event flags.

---
 rtl/mic_i2s_rx_if.sv | 52 +++++
 rtl/mic_i2s_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mic_i2s_rx_if.sv
// Signal bundle between the I2S capture receiver, the microphone pins and the audio buffer.
// Defining MIC_RX_HANDSHAKE_EN adds sample_ack/overrun for level-valid handshaking.
interface mic_i2s_rx_if #(
    parameter int unsigned WIDTH = 16
);
    logic             enable;
    logic             datain;
    logic             bclk;
    logic             rlclk;
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic             sample_valid;
    logic             busy;
`ifdef MIC_RX_HANDSHAKE_EN
    logic             sample_ack;
    logic             overrun;
`endif

    // Receiver side: generates the serial clocks and presents captured frames.
    modport master (
        input  enable,
        input  datain,
        output bclk,
        output rlclk,
        output left_data,
        output right_data,
        output sample_valid,
        output busy
`ifdef MIC_RX_HANDSHAKE_EN
        ,
        input  sample_ack,
        output overrun
`endif
    );

    // Consumer/device side.
    modport slave (
        output enable,
        output datain,
        input  bclk,
        input  rlclk,
        input  left_data,
        input  right_data,
        input  sample_valid,
        input  busy
`ifdef MIC_RX_HANDSHAKE_EN
        ,
        output sample_ack,
        input  overrun
`endif
    );
endinterface

// File: rtl/mic_i2s_rx.sv
// I2S master-mode PCM capture: generates bclk/rlclk from clk and deserializes MSB-first stereo words.
// Optional MIC_RX_HANDSHAKE_EN turns sample_valid into an acked level with a sticky overrun flag.
module mic_i2s_rx #(
    parameter int unsigned DIV   = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLOT  = 32
) (
    input logic          clk,
    input logic          reset,
    mic_i2s_rx_if.master bus
);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_LSB  = CNT_W'(WIDTH);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             rlclk_q, rlclk_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             left_done_q, left_done_d;
    logic             right_done_q, right_done_d;
`ifdef MIC_RX_HANDSHAKE_EN
    logic             overrun_q, overrun_d;
`endif

    logic div_wrap_c;
    logic rise_ev_c;
    logic fall_ev_c;
    logic capture_c;
    logic slot_end_c;

    // bclk edge events are decoded from the divider wrap and the current bclk level.
    assign div_wrap_c = (div_q == DIV_LAST);
    assign rise_ev_c  = bus.enable && div_wrap_c && !bclk_q;
    assign fall_ev_c  = bus.enable && div_wrap_c && bclk_q;
    assign capture_c  = rise_ev_c && (bitcnt_q != '0) && (bitcnt_q <= CNT_LSB);
    assign slot_end_c = rise_ev_c && (bitcnt_q == CNT_LSB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            rlclk_q      <= 1'b0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            left_done_q  <= 1'b0;
            right_done_q <= 1'b0;
`ifdef MIC_RX_HANDSHAKE_EN
            overrun_q    <= 1'b0;
`endif
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            rlclk_q      <= rlclk_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            left_done_q  <= left_done_d;
            right_done_q <= right_done_d;
`ifdef MIC_RX_HANDSHAKE_EN
            overrun_q    <= overrun_d;
`endif
        end
    end

    always_comb begin
        div_d        = div_q;
        bclk_d       = bclk_q;
        rlclk_d      = rlclk_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        left_d       = left_q;
        right_d      = right_q;
        busy_d       = busy_q;
        left_done_d  = 1'b0;
        right_done_d = 1'b0;
`ifdef MIC_RX_HANDSHAKE_EN
        valid_d      = valid_q;
        overrun_d    = overrun_q;
`else
        valid_d      = 1'b0;
`endif

        if (!bus.enable) begin
            // Idle: clocks parked low, partial frame and pending transfers dropped.
            div_d    = '0;
            bclk_d   = 1'b0;
            rlclk_d  = 1'b0;
            bitcnt_d = '0;
            shift_d  = '0;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
        end else begin
            busy_d = 1'b1;
            div_d  = div_wrap_c ? '0 : div_q + DIV_W'(1);
            if (div_wrap_c) begin
                bclk_d = !bclk_q;
            end

            if (fall_ev_c) begin
                if (bitcnt_q == CNT_LAST) begin
                    bitcnt_d = '0;
                    rlclk_d  = !rlclk_q;
                end else begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end

            if (capture_c) begin
                shift_d = {shift_q[WIDTH-2:0], bus.datain};
            end

            // Slot completion is flagged on the LSB rise and committed one clk later.
            left_done_d  = slot_end_c && !rlclk_q;
            right_done_d = slot_end_c && rlclk_q;

            if (left_done_q) begin
                hold_d = shift_q;
            end

`ifdef MIC_RX_HANDSHAKE_EN
            if (valid_q && bus.sample_ack) begin
                valid_d = 1'b0;
            end
            if (right_done_q && valid_q && !bus.sample_ack) begin
                overrun_d = 1'b1;
            end
`endif
            if (right_done_q) begin
                left_d  = hold_q;
                right_d = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    assign bus.bclk         = bclk_q;
    assign bus.rlclk        = rlclk_q;
    assign bus.left_data    = left_q;
    assign bus.right_data   = right_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
`ifdef MIC_RX_HANDSHAKE_EN
    assign bus.overrun      = overrun_q;
`endif
endmodule
